// File: rtl/minibyte_arb_pkg.sv
// Shared types and encodings for the minibyte two-master bus arbiter.
// Optional build macro used by the arbiter: MINIBYTE_ARB_LOCK_EN.
package minibyte_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic OWNER_M0 = 1'b0;
  localparam logic OWNER_M1 = 1'b1;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

  // One-hot grant vector for an owner index.
  function automatic logic [1:0] owner_gnt(input logic owner);
    return (owner == OWNER_M1) ? GNT_M1 : GNT_M0;
  endfunction

endpackage

// File: rtl/minibyte_rr_arb2.sv
// Combinational two-way round-robin picker with an optional
// keep-ownership override for the previous owner.
module minibyte_rr_arb2
  import minibyte_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_owner,
  input  logic       lock,
  output logic       winner,
  output logic       valid
);

  // Pick the requester that did not own the bus last, unless the
  // previous owner holds the lock and is still requesting.
  always_comb begin
    valid  = |req;
    winner = OWNER_M0;
    if (lock && req[last_owner]) begin
      winner = last_owner;
    end else if (req == 2'b11) begin
      winner = ~last_owner;
    end else if (req[1]) begin
      winner = OWNER_M1;
    end else begin
      winner = OWNER_M0;
    end
  end

endmodule

// File: rtl/minibyte_bus_arbiter.sv
// Two-master arbiter for the minibyte external memory/IO bus.
// Each access runs IDLE -> ADDR -> DATA (WAIT_STATES+1 cycles) -> DONE.
// Build macro MINIBYTE_ARB_LOCK_EN enables the owner keep-ownership hint;
// without it the lock inputs are ignored and arbitration is round-robin.
module minibyte_bus_arbiter
  import minibyte_arb_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned ADDR_W      = 7,
  parameter int unsigned DATA_W      = 8
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              m0_req_in,
  input  logic              m0_we_in,
  input  logic [ADDR_W-1:0] m0_addr_in,
  input  logic [DATA_W-1:0] m0_data_in,
  input  logic              m0_lock_in,
  output logic              m0_ack_out,
  input  logic              m1_req_in,
  input  logic              m1_we_in,
  input  logic [ADDR_W-1:0] m1_addr_in,
  input  logic [DATA_W-1:0] m1_data_in,
  input  logic              m1_lock_in,
  output logic              m1_ack_out,
  output logic [DATA_W-1:0] rdata_out,
  output logic [ADDR_W-1:0] bus_addr_out,
  output logic [DATA_W-1:0] bus_data_out,
  input  logic [DATA_W-1:0] bus_data_in,
  output logic              bus_we_out,
  output logic              bus_drive_out,
  output logic [1:0]        gnt_out,
  output logic              busy_out
);

  localparam logic [2:0] WAIT_INIT = 3'(WAIT_STATES);

  state_t            state;
  logic              owner;
  logic              last_owner;
  logic              lat_we;
  logic [2:0]        wait_cnt;
  logic              lock_flag;

  logic              arb_winner;
  logic              arb_valid;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              owner_lock;

  minibyte_rr_arb2 u_pick (
    .req        ({m1_req_in, m0_req_in}),
    .last_owner (last_owner),
    .lock       (lock_flag),
    .winner     (arb_winner),
    .valid      (arb_valid)
  );

  // Route the winning master's transaction fields to the latch point.
  always_comb begin
    sel_we   = (arb_winner == OWNER_M1) ? m1_we_in   : m0_we_in;
    sel_addr = (arb_winner == OWNER_M1) ? m1_addr_in : m0_addr_in;
    sel_data = (arb_winner == OWNER_M1) ? m1_data_in : m0_data_in;
  end

`ifdef MINIBYTE_ARB_LOCK_EN
  // The current owner's keep-ownership hint, sampled while in DONE.
  always_comb begin
    owner_lock = (owner == OWNER_M1) ? m1_lock_in : m0_lock_in;
  end
`else
  logic unused_lock;
  assign unused_lock = m0_lock_in ^ m1_lock_in;

  // Lock hint has no effect in this build.
  always_comb begin
    owner_lock = 1'b0;
  end
`endif

  // Access sequencer: arbitration, bus phases, read capture and ack.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state         <= IDLE;
      owner         <= OWNER_M0;
      last_owner    <= OWNER_M1;
      lat_we        <= 1'b0;
      wait_cnt      <= 3'd0;
      lock_flag     <= 1'b0;
      m0_ack_out    <= 1'b0;
      m1_ack_out    <= 1'b0;
      rdata_out     <= '0;
      bus_addr_out  <= '0;
      bus_data_out  <= '0;
      bus_we_out    <= 1'b0;
      bus_drive_out <= 1'b0;
      gnt_out       <= GNT_NONE;
      busy_out      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_valid) begin
            owner         <= arb_winner;
            lat_we        <= sel_we;
            lock_flag     <= 1'b0;
            bus_addr_out  <= sel_addr;
            bus_data_out  <= sel_we ? sel_data : '0;
            bus_drive_out <= sel_we;
            bus_we_out    <= 1'b0;
            gnt_out       <= owner_gnt(arb_winner);
            busy_out      <= 1'b1;
            state         <= ADDR;
          end
        end
        ADDR: begin
          bus_we_out <= lat_we;
          wait_cnt   <= WAIT_INIT;
          state      <= DATA;
        end
        DATA: begin
          if (wait_cnt == 3'd0) begin
            bus_we_out    <= 1'b0;
            bus_drive_out <= 1'b0;
            if (!lat_we) begin
              rdata_out <= bus_data_in;
            end
            m0_ack_out <= (owner == OWNER_M0);
            m1_ack_out <= (owner == OWNER_M1);
            state      <= DONE;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        DONE: begin
          m0_ack_out <= 1'b0;
          m1_ack_out <= 1'b0;
          gnt_out    <= GNT_NONE;
          busy_out   <= 1'b0;
          last_owner <= owner;
          lock_flag  <= owner_lock;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_minibyte_bus_arbiter.sv
// Randomized scoreboard bench for minibyte_bus_arbiter with a
// transaction-level reference model and a bus-side memory model.
module tb_minibyte_bus_arbiter;

  localparam int WS = 1;
  localparam int AW = 7;
  localparam int DW = 8;

  typedef struct {
    logic          m;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [DW-1:0] rdata;
    int            ack_cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    req, we, lock;
  logic [AW-1:0] addr [2];
  logic [DW-1:0] wdata [2];
  logic          ack0, ack1, bus_we, bus_drive, busy;
  logic [DW-1:0] rdata, bus_wdata, bus_rdata;
  logic [AW-1:0] bus_addr;
  logic [1:0]    gnt;

  logic [DW-1:0] mem_dut [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];

  exp_t q[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   mode = 0;
  logic lock_m1 = 1'b0;
  logic [1:0] hold = 2'b00;
  int   we_cnt = 0;
  int   drv_cnt = 0;

  // reference model state
  logic          m_busy, m_last, m_lockf, m_owner, m_cur_we;
  logic [AW-1:0] m_cur_addr;
  logic [DW-1:0] m_old, m_rdata;
  int            m_done, m_next;

  always #5 clk = ~clk;

  assign bus_rdata = mem_dut[bus_addr];

  minibyte_bus_arbiter #(.WAIT_STATES(WS), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_in(clk), .rst_in(rst_n),
    .m0_req_in(req[0]), .m0_we_in(we[0]), .m0_addr_in(addr[0]),
    .m0_data_in(wdata[0]), .m0_lock_in(lock[0]), .m0_ack_out(ack0),
    .m1_req_in(req[1]), .m1_we_in(we[1]), .m1_addr_in(addr[1]),
    .m1_data_in(wdata[1]), .m1_lock_in(lock[1]), .m1_ack_out(ack1),
    .rdata_out(rdata), .bus_addr_out(bus_addr), .bus_data_out(bus_wdata),
    .bus_data_in(bus_rdata), .bus_we_out(bus_we), .bus_drive_out(bus_drive),
    .gnt_out(gnt), .busy_out(busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name, input int a, input int b);
    checks++;
    errors++;
    $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, a, b, cyc);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ack0"},  32'(ack0), 0);
    check({tag, "_ack1"},  32'(ack1), 0);
    check({tag, "_rdata"}, 32'(rdata), 0);
    check({tag, "_addr"},  32'(bus_addr), 0);
    check({tag, "_wdata"}, 32'(bus_wdata), 0);
    check({tag, "_we"},    32'(bus_we), 0);
    check({tag, "_drive"}, 32'(bus_drive), 0);
    check({tag, "_gnt"},   32'(gnt), 0);
    check({tag, "_busy"},  32'(busy), 0);
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_last = 1'b1; m_lockf = 1'b0; m_owner = 1'b0;
    m_cur_we = 1'b0; m_cur_addr = '0; m_old = '0; m_rdata = '0;
    m_done = 0; m_next = 0;
  endtask

  // Transaction-level view: one access per 4+WS cycles, requests sampled
  // only when the arbiter is idle, winner from the fairness/lock rules.
  task automatic model_step();
    exp_t e;
    logic w;
    if (m_busy && cyc == m_done) begin
      m_last = m_owner;
`ifdef MINIBYTE_ARB_LOCK_EN
      m_lockf = lock[m_owner];
`else
      m_lockf = 1'b0;
`endif
      m_busy = 1'b0;
      m_next = cyc + 1;
    end
    if (!m_busy && cyc >= m_next && req != 2'b00) begin
      if (m_lockf && req[m_last]) w = m_last;
      else w = req[!m_last] ? !m_last : m_last;
      e.m = w; e.we = we[w]; e.addr = addr[w]; e.data = wdata[w];
      if (e.we) begin
        m_old = ref_mem[e.addr];
        ref_mem[e.addr] = e.data;
        e.rdata = m_rdata;
      end else begin
        e.rdata = ref_mem[e.addr];
      end
      m_rdata = e.rdata;
      e.ack_cyc = cyc + 3 + WS;
      m_cur_we = e.we; m_cur_addr = e.addr;
      m_owner = w; m_done = e.ack_cyc; m_busy = 1'b1; m_lockf = 1'b0;
      q.push_back(e);
    end
  endtask

  // Edge process: cycle count, external memory writes, reference model.
  initial forever begin
    @(posedge clk);
    cyc++;
    if (bus_we) mem_dut[bus_addr] = bus_wdata;
    if (rst_n) model_step();
  end

  // Monitor: invariants every cycle, scoreboard pop on each ack.
  initial forever begin
    exp_t e;
    int   now;
    @(negedge clk);
    if (rst_n) begin
      now = cyc + 1;
      check("ack_exclusive", 32'(ack0 & ack1), 0);
      check("gnt_not_both", 32'(gnt == 2'b11), 0);
      if (bus_we) we_cnt++;
      if (bus_drive) drv_cnt++;
      if (ack0 || ack1) begin
        if (q.size() == 0) begin
          fail_now("unexpected_ack", 1, 0);
        end else begin
          e = q.pop_front();
          check("ack_master", 32'({ack1, ack0}), e.m ? 32'd2 : 32'd1);
          check("ack_cycle", 32'(now), 32'(e.ack_cyc));
          check("rdata", 32'(rdata), 32'(e.rdata));
          check("gnt_in_done", 32'(gnt), e.m ? 32'd2 : 32'd1);
          check("bus_addr_done", 32'(bus_addr), 32'(e.addr));
          check("busy_in_done", 32'(busy), 1);
          check("we_cycles", 32'(we_cnt), e.we ? 32'(WS + 1) : 32'd0);
          check("drive_cycles", 32'(drv_cnt), e.we ? 32'(WS + 2) : 32'd0);
          if (e.we) begin
            check("mem_written", 32'(mem_dut[e.addr]), 32'(e.data));
            check("bus_wdata", 32'(bus_wdata), 32'(e.data));
          end
        end
        we_cnt = 0;
        drv_cnt = 0;
      end else if (q.size() != 0 && now > q[0].ack_cyc) begin
        fail_now("missing_ack", now, q[0].ack_cyc);
        void'(q.pop_front());
        we_cnt = 0;
        drv_cnt = 0;
      end
    end
  end

  task automatic new_txn(input int i);
    req[i]   = 1'b1;
    we[i]    = 1'($urandom);
    addr[i]  = AW'($urandom);
    wdata[i] = DW'($urandom);
  endtask

  // Master drivers: mode 0 finish only, 1 random, 2 request continuously.
  initial forever begin
    logic a;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      a = (i == 1) ? ack1 : ack0;
      if (a) begin
        hold[i] = 1'b0;
        if (mode == 2) new_txn(i);
        else req[i] = 1'b0;
      end else if (req[i] && gnt[i] && mode == 1 && $urandom_range(0, 7) == 0) begin
        req[i]   = 1'b0;
        hold[i]  = 1'b1;
        we[i]    = 1'($urandom);
        addr[i]  = AW'($urandom);
        wdata[i] = DW'($urandom);
      end else if (!req[i] && !hold[i] && mode != 0 &&
                   (mode == 2 || $urandom_range(0, 3) == 0)) begin
        new_txn(i);
      end
      lock[i] = (mode == 1) ? 1'($urandom) : ((i == 1) ? lock_m1 : 1'b0);
    end
  end

  task automatic drain();
    int n;
    mode = 0;
    n = 0;
    while (!(q.size() == 0 && !m_busy && req == 2'b00) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) fail_now("drain_timeout", n, 300);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [DW-1:0] v;
    int n;
    for (int i = 0; i < (1 << AW); i++) begin
      v = DW'($urandom);
      mem_dut[i] = v;
      ref_mem[i] = v;
    end
    req = '0; we = '0; lock = '0;
    addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
    model_reset();

    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    mode = 1;
    repeat (1500) @(negedge clk);
    drain();

    mode = 2;
    repeat (120) @(negedge clk);
    drain();

    lock_m1 = 1'b1;
    mode = 2;
    repeat (120) @(negedge clk);
    drain();
    lock_m1 = 1'b0;

    // write interrupted by reset in its first data cycle
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 7'h7F; wdata[1] = 8'h3C;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus_we && n < 20);
    if (!bus_we) fail_now("write_start_timeout", n, 20);
    rst_n = 1'b0;
    if (m_busy && m_cur_we) ref_mem[m_cur_addr] = m_old;
    q.delete();
    model_reset();
    hold = 2'b00;
    we_cnt = 0;
    drv_cnt = 0;
    #1;
    check_zero("mid_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drain();

    mode = 1;
    repeat (800) @(negedge clk);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
